shift_cmd_serializer: RTL and testbench
=======================================

Name: shift_cmd_serializer

Overview:
- Upstream feeder for the 32-bit two-party shift register.
- Captures one W-bit move word per party (garbler g_, evaluator e_) and a step count.
- Replays the words one bit per cycle on g_input/e_input, LSB first, so the downstream register sees one move pair per cycle.
- Frames the burst with valid/busy/done and a step counter so the enclosing sequential garbled circuit knows when the shift phase ends.

Parameters:
- W, 8, bits per party move word; also the maximum burst length.
- LW, $clog2(W+1), width of len and step_cnt.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; honoured only in IDLE or DONE
- g_init  in  W  garbler move word, sampled on accepted start
- e_init  in  W  evaluator move word, sampled on accepted start
- len  in  LW  number of steps to emit; values above W clamp to W
- g_input  out  1  registered garbler move bit; 0 whenever valid=0
- e_input  out  1  registered evaluator move bit; 0 whenever valid=0
- valid  out  1  high on each cycle a move pair is presented
- busy  out  1  high in RUN
- done  out  1  high in DONE; held until the next accepted start or reset
- step_cnt  out  LW  number of pairs emitted in the current burst
- net_shift  out  LW+1  signed; present only with the optional feature (see below)

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, immediate):
  - state=IDLE.
  - g_input, e_input, valid, busy and done are all 0; step_cnt=0.
  - Internal g/e shift words are 0; net_shift=0.
- Accepted start (IDLE or DONE):
  - Capture g_init, e_init and min(len,W); clear step_cnt; clear done.
  - If the effective len is 0: next state is DONE, valid never rises, done=1 on cycle t+1.
  - Otherwise: next state is RUN.
- Latency: with start at edge t, the first pair is visible after edge t+1 with valid=1.
- RUN, each cycle:
  - Outputs are g_word[0] and e_word[0]; both words shift right, zero-filled.
  - step_cnt increments.
  - When step_cnt reaches the effective len, the next state is DONE.
  - On the cycle after the last pair: valid=0, g_input=e_input=0, busy=0, done=1.
- Output gating: in every cycle with valid=0, outputs are forced to 0/0, which is a hold for the downstream register.
- Equal pairs (1/1 or 0/0) during RUN are passed through unchanged. They are legal and are no-ops downstream.
- start during RUN is ignored; the burst is not restarted or extended.
- start in DONE begins a new burst directly, without passing through IDLE.
- rst mid-RUN: immediate return to IDLE with all outputs 0. The partial burst is lost and nothing is replayed.
- Width rules:
  - step_cnt never exceeds W.
  - len is compared only after clamping.
  - No wrap is possible because the clamped len is ≤ W < 2^LW.

Optional Feature:
- Macro: SHIFT_CMD_NET_SHIFT_EN.
- With the macro: a net_shift port is added. It is a signed LW+1-bit counter, cleared on accepted start.
  - +1 for each emitted pair g=1,e=0 (right shift).
  - −1 for each emitted pair g=0,e=1 (left shift).
  - Unchanged for equal pairs.
  - Holds its value in DONE.
- Without the macro: no net_shift port and no counter logic.

Decomposition:
- Package shift_cmd_pkg:
  - State enum: IDLE/RUN/DONE.
  - Default W constant.
  - Clamp function min(len,W).
- Sub-module piso_bit_reg: a W-bit load/shift-right register with bit-0 output. Instantiated twice, once for g and once for e.

Test Plan:
- W=8, g_init=8'hFF, e_init=8'h00, len=8, start pulse → valid high for 8 cycles with g/e=1/0, then done=1 and step_cnt=8. With the downstream register chained, o goes 0x00FF_gg_ee → 0x0000_FF_gg.
- g_init=8'h0A, e_init=8'h05, len=4 → pairs (0,1),(1,0),(0,1),(1,0); step_cnt=4; net_shift=0 (macro on).
- len=0 → done=1 one cycle after start; valid, g_input and e_input stay 0 throughout.
- len=12, W=8 → exactly 8 pairs emitted; step_cnt=8; no ninth valid.
- rst asserted after the 3rd pair → same cycle: valid=0, busy=0, done=0, step_cnt=0. A later start runs a fresh full burst.
- start pulsed during RUN → ignored, burst length unchanged. start pulsed in DONE with new words → new burst begins on the next cycle.

Source files
------------

// File: rtl/shift_cmd_pkg.sv
// Shared types and helpers for the shift command serializer: FSM states,
// default move-word width and the burst-length clamp.
package shift_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_W = 8;

  function automatic int clamp_len(input int len_v, input int w_max);
    return (len_v > w_max) ? w_max : len_v;
  endfunction

endpackage

// File: rtl/piso_bit_reg.sv
// W-bit parallel-load register that shifts right with zero fill and
// presents bit 0 as the serial output.
module piso_bit_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         bit0
);

  logic [W-1:0] word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (load) begin
      word <= din;
    end else if (shift) begin
      word <= {1'b0, word[W-1:1]};
    end
  end

  assign bit0 = word[0];

endmodule

// File: rtl/shift_cmd_serializer.sv
// Replays one garbler/evaluator move word pair LSB first, one pair per cycle,
// framed by valid/busy/done. Optional SHIFT_CMD_NET_SHIFT_EN adds net_shift.
module shift_cmd_serializer
  import shift_cmd_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int LW = $clog2(W + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W-1:0]         g_init,
  input  logic [W-1:0]         e_init,
  input  logic [LW-1:0]        len,
  output logic                 g_input,
  output logic                 e_input,
  output logic                 valid,
  output logic                 busy,
  output logic                 done,
  output logic [LW-1:0]        step_cnt
`ifdef SHIFT_CMD_NET_SHIFT_EN
  ,
  output logic signed [LW:0]   net_shift
`endif
);

  state_t        state, state_nx;
  logic          accept;
  logic          run;
  logic          g_bit, e_bit;
  logic [LW-1:0] len_eff;
  logic [LW-1:0] len_q;
  logic [LW-1:0] step_nx;

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign run     = (state == RUN);
  assign len_eff = LW'(clamp_len(int'(len), W));
  assign step_nx = step_cnt + LW'(1);

  piso_bit_reg #(.W(W)) u_g_word (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (run),
    .din   (g_init),
    .bit0  (g_bit)
  );

  piso_bit_reg #(.W(W)) u_e_word (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (run),
    .din   (e_init),
    .bit0  (e_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = (len_eff == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (step_nx == len_q) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode straight from flops; zero whenever no pair is presented.
  always_comb begin
    valid   = (state == RUN);
    busy    = (state == RUN);
    done    = (state == DONE);
    g_input = valid & g_bit;
    e_input = valid & e_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      step_cnt <= '0;
    end else if (accept) begin
      len_q    <= len_eff;
      step_cnt <= '0;
    end else if (run) begin
      step_cnt <= step_nx;
    end
  end

`ifdef SHIFT_CMD_NET_SHIFT_EN
  localparam logic signed [LW:0] NS_ONE = (LW + 1)'(1);

  // g=1,e=0 is a right shift (+1); g=0,e=1 a left shift (-1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      net_shift <= '0;
    end else if (accept) begin
      net_shift <= '0;
    end else if (run) begin
      case ({g_bit, e_bit})
        2'b10:   net_shift <= net_shift + NS_ONE;
        2'b01:   net_shift <= net_shift - NS_ONE;
        default: net_shift <= net_shift;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_shift_cmd_serializer.sv
// Directed self-checking bench for shift_cmd_serializer (W=8); net_shift
// checks are compiled in when SHIFT_CMD_NET_SHIFT_EN is defined.
module tb_shift_cmd_serializer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] g_init;
  logic [7:0] e_init;
  logic [3:0] len;
  logic       g_input;
  logic       e_input;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] step_cnt;
`ifdef SHIFT_CMD_NET_SHIFT_EN
  logic signed [4:0] net_shift;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  shift_cmd_serializer #(.W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .g_init   (g_init),
    .e_init   (e_init),
    .len      (len),
    .g_input  (g_input),
    .e_input  (e_input),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .step_cnt (step_cnt)
`ifdef SHIFT_CMD_NET_SHIFT_EN
    ,
    .net_shift(net_shift)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives start for one cycle; returns at the negedge after the accepting edge.
  task automatic pulse_start(input logic [7:0] g, input logic [7:0] e, input logic [3:0] l);
    @(negedge clk);
    g_init = g;
    e_init = e;
    len    = l;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    g_init = '0;
    e_init = '0;
    len = '0;
    #1;
    n_checks++;
    if ({valid, busy, done, g_input, e_input, step_cnt} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_async: got v/b/d/g/e/step=%b%b%b%b%b/%0d want all 0",
               valid, busy, done, g_input, e_input, step_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({valid, busy, done, g_input, e_input, step_cnt} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got v/b/d/g/e/step=%b%b%b%b%b/%0d want all 0",
               valid, busy, done, g_input, e_input, step_cnt);
    end
  endtask

  task automatic test_full_ones();
    pulse_start(8'hFF, 8'h00, 4'd8);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({valid, busy, done, g_input, e_input} !== 5'b11010) begin
        n_fail++;
        $display("FAIL full_pair%0d: got v/b/d/g/e=%b%b%b%b%b want 11010",
                 i, valid, busy, done, g_input, e_input);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({valid, busy, done, g_input, e_input, step_cnt} !== {5'b00100, 4'd8}) begin
      n_fail++;
      $display("FAIL full_end: got v/b/d/g/e/step=%b%b%b%b%b/%0d want 00100/8",
               valid, busy, done, g_input, e_input, step_cnt);
    end
`ifdef SHIFT_CMD_NET_SHIFT_EN
    n_checks++;
    if (net_shift !== 5'sd8) begin
      n_fail++;
      $display("FAIL full_net_shift: got %0d want 8", net_shift);
    end
`endif
    @(negedge clk);
    n_checks++;
    if ({valid, done} !== 2'b01) begin
      n_fail++;
      $display("FAIL full_done_hold: got valid/done=%b%b want 01", valid, done);
    end
  endtask

  task automatic test_alternating();
    logic [3:0] exp_g;
    logic [3:0] exp_e;
    exp_g = 4'b1010;
    exp_e = 4'b0101;
    pulse_start(8'h0A, 8'h05, 4'd4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({valid, g_input, e_input} !== {1'b1, exp_g[i], exp_e[i]}) begin
        n_fail++;
        $display("FAIL alt_pair%0d: got v/g/e=%b%b%b want 1%b%b",
                 i, valid, g_input, e_input, exp_g[i], exp_e[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({valid, done, step_cnt} !== {2'b01, 4'd4}) begin
      n_fail++;
      $display("FAIL alt_end: got valid/done/step=%b%b/%0d want 01/4", valid, done, step_cnt);
    end
`ifdef SHIFT_CMD_NET_SHIFT_EN
    n_checks++;
    if (net_shift !== 5'sd0) begin
      n_fail++;
      $display("FAIL alt_net_shift: got %0d want 0", net_shift);
    end
`endif
  endtask

  task automatic test_len_zero();
    pulse_start(8'hFF, 8'hFF, 4'd0);
    n_checks++;
    if ({valid, busy, done, g_input, e_input, step_cnt} !== {5'b00100, 4'd0}) begin
      n_fail++;
      $display("FAIL len0_done: got v/b/d/g/e/step=%b%b%b%b%b/%0d want 00100/0",
               valid, busy, done, g_input, e_input, step_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({valid, g_input, e_input, done} !== 4'b0001) begin
        n_fail++;
        $display("FAIL len0_quiet%0d: got v/g/e/d=%b%b%b%b want 0001",
                 i, valid, g_input, e_input, done);
      end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] gw;
    int         nvalid;
    gw = 8'h81;
    nvalid = 0;
    pulse_start(gw, 8'h00, 4'd12);
    for (int i = 0; i < 12; i++) begin
      if (valid) begin
        n_checks++;
        if (nvalid >= 8 || g_input !== gw[nvalid] || e_input !== 1'b0) begin
          n_fail++;
          $display("FAIL clamp_pair%0d: got g/e=%b%b want %b0 (or extra valid)",
                   nvalid, g_input, e_input, (nvalid < 8) ? gw[nvalid] : 1'b0);
        end
        nvalid++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (nvalid != 8) begin
      n_fail++;
      $display("FAIL clamp_count: got %0d valid cycles want 8", nvalid);
    end
    n_checks++;
    if ({done, step_cnt} !== {1'b1, 4'd8}) begin
      n_fail++;
      $display("FAIL clamp_end: got done/step=%b/%0d want 1/8", done, step_cnt);
    end
  endtask

  task automatic test_rst_mid_run();
    logic [7:0] gw;
    logic [7:0] ew;
    pulse_start(8'hFF, 8'hFF, 4'd8);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({valid, busy, done, g_input, e_input, step_cnt} !== 9'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got v/b/d/g/e/step=%b%b%b%b%b/%0d want all 0",
               valid, busy, done, g_input, e_input, step_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    gw = 8'h3C;
    ew = 8'hC3;
    pulse_start(gw, ew, 4'd8);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({valid, g_input, e_input} !== {1'b1, gw[i], ew[i]}) begin
        n_fail++;
        $display("FAIL rst_fresh_pair%0d: got v/g/e=%b%b%b want 1%b%b",
                 i, valid, g_input, e_input, gw[i], ew[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({valid, done, step_cnt} !== {2'b01, 4'd8}) begin
      n_fail++;
      $display("FAIL rst_fresh_end: got valid/done/step=%b%b/%0d want 01/8", valid, done, step_cnt);
    end
  endtask

  task automatic test_start_during_run();
    logic [7:0] gw;
    logic [7:0] ew;
    int         nvalid;
    gw = 8'hF0;
    ew = 8'h0F;
    nvalid = 0;
    pulse_start(gw, ew, 4'd5);
    for (int i = 0; i < 10; i++) begin
      if (valid) begin
        n_checks++;
        if (nvalid >= 5 || g_input !== gw[nvalid] || e_input !== ew[nvalid]) begin
          n_fail++;
          $display("FAIL run_start_pair%0d: got g/e=%b%b (or extra valid)", nvalid, g_input, e_input);
        end
        nvalid++;
      end
      start = (i == 1);
      if (i == 1) begin
        g_init = 8'hAA;
        e_init = 8'hAA;
        len    = 4'd8;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (nvalid != 5 || step_cnt !== 4'd5 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL run_start_len: got %0d pairs step=%0d done=%b want 5/5/1", nvalid, step_cnt, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_g;
    logic [2:0] exp_e;
    exp_g = 3'b101;
    exp_e = 3'b010;
    pulse_start(8'h55, 8'hAA, 4'd3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({valid, done, g_input, e_input} !== {2'b10, exp_g[i], exp_e[i]}) begin
        n_fail++;
        $display("FAIL done_start_pair%0d: got v/d/g/e=%b%b%b%b want 10%b%b",
                 i, valid, done, g_input, e_input, exp_g[i], exp_e[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({valid, done, step_cnt} !== {2'b01, 4'd3}) begin
      n_fail++;
      $display("FAIL done_start_end: got valid/done/step=%b%b/%0d want 01/3", valid, done, step_cnt);
    end
`ifdef SHIFT_CMD_NET_SHIFT_EN
    n_checks++;
    if (net_shift !== 5'sd1) begin
      n_fail++;
      $display("FAIL done_start_net_shift: got %0d want 1", net_shift);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_ones();
    test_alternating();
    test_len_zero();
    test_clamp();
    test_rst_mid_run();
    test_start_during_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
